// File: rtl/i2s_rx_offset_binary.sv
// I2S stereo receiver with two's-complement to offset-binary conversion.
// The three I2S pins are synchronised into the clk domain, and BCLK rising
// edges are detected there. Each left/right slot is deserialised MSB first.
// A completed pair is presented as offset-binary words under valid/ready.
module i2s_rx_offset_binary #(
  parameter int AUDIO_DW = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_sdata,
  output logic [AUDIO_DW-1:0] dout_left,
  output logic [AUDIO_DW-1:0] dout_right,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                overrun
);

  localparam int CW = $clog2(AUDIO_DW + 1);
  localparam logic [CW-1:0]       CNT_MAX  = CW'(AUDIO_DW);
  localparam logic [AUDIO_DW-1:0] MIDSCALE = {1'b1, {(AUDIO_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  // Bit 0 = bclk, bit 1 = lrclk, bit 2 = sdata. All three pins share one
  // synchroniser depth, so lr and sd line up with the detected bclk edge.
  logic [2:0] pins;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic       bclk_prev_q;

  assign pins = {i2s_sdata, i2s_lrclk, i2s_bclk};

  // Two-flop synchroniser for the asynchronous I2S pins
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
    end
  end

  // Remember the previous synchronised bclk level for rising-edge detection
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_prev_q <= sync2_q[0];
    end
  end

  logic bclk_rise;
  logic lr_s;
  logic sd_s;

  assign bclk_rise = sync2_q[0] & ~bclk_prev_q;
  assign lr_s      = sync2_q[1];
  assign sd_s      = sync2_q[2];

  // ---------------------------------------------------------------------
  // Slot deserialiser and frame state machine
  // ---------------------------------------------------------------------
  state_t              state_q;
  logic                lr_prev_q;
  logic [CW-1:0]       bit_cnt_q;
  logic [AUDIO_DW-1:0] left_sr_q;
  logic [AUDIO_DW-1:0] right_sr_q;
  logic                pair_done_q;
  logic [AUDIO_DW-1:0] pair_left_q;
  logic [AUDIO_DW-1:0] pair_right_q;

  logic                boundary;
  logic                slot_room;
  logic [AUDIO_DW-1:0] bit_sel;
  logic [AUDIO_DW-1:0] left_sr_d;
  logic [AUDIO_DW-1:0] right_sr_d;

  // A change of lr between successive bclk rises marks a slot boundary
  assign boundary  = bclk_rise & (lr_s != lr_prev_q);
  assign slot_room = (bit_cnt_q < CNT_MAX);

  // One-hot select of the register bit that receives the current data bit.
  // MSB first: bit count 0 lands at AUDIO_DW-1. A saturated count selects nothing.
  genvar gi;
  generate
    for (gi = 0; gi < AUDIO_DW; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (bit_cnt_q == CW'(AUDIO_DW - 1 - gi));
    end
  endgenerate

  // Channel registers with the current data bit merged in
  assign left_sr_d  = (left_sr_q  & ~bit_sel) | (bit_sel & {AUDIO_DW{sd_s}});
  assign right_sr_d = (right_sr_q & ~bit_sel) | (bit_sel & {AUDIO_DW{sd_s}});

  // Frame FSM: track slot boundaries, shift data into the active channel, and
  // snapshot the pair when the right slot ends
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_SYNC;
      lr_prev_q    <= 1'b0;
      bit_cnt_q    <= '0;
      left_sr_q    <= '0;
      right_sr_q   <= '0;
      pair_done_q  <= 1'b0;
      pair_left_q  <= '0;
      pair_right_q <= '0;
    end else begin
      pair_done_q <= 1'b0;
      if (bclk_rise) begin
        lr_prev_q <= lr_s;
        if (boundary) begin
          // The boundary bit is the I2S one-bit delay slot and carries no
          // data for the new channel.
          bit_cnt_q <= '0;
          if (lr_s) begin
            // Rising lr (0->1): a right slot begins.
            right_sr_q <= '0;
            unique case (state_q)
              ST_LEFT:  state_q <= ST_RIGHT;
              ST_RIGHT: state_q <= ST_RIGHT;
              default:  state_q <= ST_SYNC;
            endcase
          end else begin
            // Falling lr (1->0): a left slot begins. Left is cleared in every
            // state. An extra transition seen in LEFT restarts left capture.
            left_sr_q <= '0;
            unique case (state_q)
              ST_RIGHT: begin
                // Nonblocking reads return the completed pre-clear contents.
                pair_done_q  <= 1'b1;
                pair_left_q  <= left_sr_q;
                pair_right_q <= right_sr_q;
                state_q      <= ST_LEFT;
              end
              default: state_q <= ST_LEFT;
            endcase
          end
        end else if (slot_room) begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
          unique case (state_q)
            ST_LEFT:  left_sr_q  <= left_sr_d;
            ST_RIGHT: right_sr_q <= right_sr_d;
            default:  ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output stage: offset-binary conversion and valid/ready handshake
  // ---------------------------------------------------------------------
  logic [AUDIO_DW-1:0] dout_left_q;
  logic [AUDIO_DW-1:0] dout_right_q;
  logic                dout_valid_q;
  logic                overrun_q;

  // Load each completed pair with the MSB inverted. A pair that replaces an
  // unaccepted one sets the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout_left_q  <= MIDSCALE;
      dout_right_q <= MIDSCALE;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (pair_done_q) begin
      dout_left_q  <= {~pair_left_q[AUDIO_DW-1],  pair_left_q[AUDIO_DW-2:0]};
      dout_right_q <= {~pair_right_q[AUDIO_DW-1], pair_right_q[AUDIO_DW-2:0]};
      dout_valid_q <= 1'b1;
      if (dout_valid_q && !dout_ready) begin
        overrun_q <= 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign dout_left  = dout_left_q;
  assign dout_right = dout_right_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_rx_offset_binary.sv
// Testbench for i2s_rx_offset_binary: drives I2S frames from the bench and
// keeps a scoreboard of expected offset-binary pairs that a negedge monitor
// pops on every handshake.
`timescale 1ns/1ps
module tb_i2s_rx_offset_binary;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          i2s_bclk = 1'b0;
  logic          i2s_lrclk = 1'b0;
  logic          i2s_sdata = 1'b0;
  logic          dout_ready = 1'b1;
  logic [DW-1:0] dout_left;
  logic [DW-1:0] dout_right;
  logic          dout_valid;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected pairs, {left, right}, in emission order
  logic [2*DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  i2s_rx_offset_binary #(.AUDIO_DW(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata),
    .dout_left  (dout_left),
    .dout_right (dout_right),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  // Expected output word for a slot sending the top n bits of lj, MSB first
  function automatic logic [DW-1:0] exp_word(input logic [31:0] lj, input int n);
    logic [31:0] mask;
    logic [31:0] kept;
    logic [15:0] cap;
    mask = (n >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> n);
    kept = lj & mask;
    cap  = kept[31:16];
    return {~cap[15], cap[14:0]};
  endfunction

  // Scoreboard monitor: compare every accepted pair against the queue head
  always @(negedge clk) begin
    if (resetn && dout_valid && dout_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pair_unexpected: got %h/%h, required no pair", dout_left, dout_right);
      end else begin
        logic [2*DW-1:0] e;
        e = exp_q.pop_front();
        if ({dout_left, dout_right} !== e) begin
          n_fail++;
          $display("FAIL pair_data: got %h/%h, required %h/%h",
                   dout_left, dout_right, e[2*DW-1:DW], e[DW-1:0]);
        end else begin
          $display("pair ok: %h/%h", dout_left, dout_right);
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bclk period: low phase with lr/sd set up, then a rise held for 4 clk.
  // mode 1 checks the 4-clk valid latency; mode 2 pulses ready in the
  // pair_done cycle so it coincides with the new pair loading.
  task automatic bit_cycle(input logic lr, input logic sd, input int mode);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdata = sd;
    tick(4);
    i2s_bclk = 1'b1;
    if (mode == 1) begin
      tick(3);
      n_checks++;
      if (dout_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_early: valid %b after 3 clk, required 0", dout_valid);
      end
      tick(1);
      n_checks++;
      if (dout_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL latency_4clk: valid %b after 4 clk, required 1", dout_valid);
      end
    end else if (mode == 2) begin
      tick(3);
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
    end else begin
      tick(4);
    end
  endtask

  // A slot: a boundary bit if lr changes, then n data bits, MSB first
  task automatic send_slot(input logic lr, input logic [31:0] lj, input int n);
    if (lr !== i2s_lrclk) bit_cycle(lr, 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < n; i++) bit_cycle(lr, lj[31-i], 0);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit push);
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
    if (push) exp_q.push_back({exp_word(l, n), exp_word(r, n)});
  endtask

  // Falling-lr boundary that closes the preceding frame
  task automatic flush(input int mode);
    bit_cycle(1'b0, 1'($urandom_range(0, 1)), mode);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick(3);
    n_checks++;
    if (dout_left !== 16'h8000) begin n_fail++; $display("FAIL reset_left: got %h, required 8000", dout_left); end
    n_checks++;
    if (dout_right !== 16'h8000) begin n_fail++; $display("FAIL reset_right: got %h, required 8000", dout_right); end
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", dout_valid); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    resetn = 1'b1;
    tick(2);
  endtask

  task automatic test_basic;
    send_frame(32'hAAAA_0000, 32'h5555_0000, 16, 1'b0);
    send_slot(1'b0, 32'h1234_0000, 16);
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL sync_no_pair: valid %b, required 0", dout_valid); end
    send_slot(1'b1, 32'hFFFF_0000, 16);
    exp_q.push_back({16'h9234, 16'h7FFF});
    flush(1);
    tick(2);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL basic_drain: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_extremes;
    send_frame(32'h8000_0000, 32'h7FFF_0000, 16, 1'b1);
    send_frame(32'h0000_0000, 32'h0000_0000, 16, 1'b1);
    flush(0);
    tick(2);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL extremes_drain: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_long_slots;
    send_frame(32'h1234_5600, 32'hABCD_EF00, 32, 1'b1);
    flush(0);
    tick(2);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL long_drain: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_short_slots;
    send_frame(32'h7F00_0000, 32'h8000_0000, 8, 1'b1);
    flush(0);
    tick(2);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL short_drain: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] l;
    logic [15:0] r;
    for (int k = 0; k < 3; k++) begin
      l = 16'($urandom_range(0, 65535));
      r = 16'($urandom_range(0, 65535));
      send_frame({l, 16'h0}, {r, 16'h0}, 16, 1'b1);
    end
    flush(0);
    tick(2);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_drain: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_simultaneous;
    dout_ready = 1'b0;
    send_frame(32'h0F0F_0000, 32'hF0F0_0000, 16, 1'b1);
    send_frame(32'h3C3C_0000, 32'hC3C3_0000, 16, 1'b1);
    flush(2);
    n_checks++;
    if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid: got %b, required 1", dout_valid); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL simul_overrun: got %b, required 0", overrun); end
    dout_ready = 1'b1;
    tick(2);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL simul_drain: %0d pending, required 0", exp_q.size()); end
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL simul_valid_clear: got %b, required 0", dout_valid); end
  endtask

  task automatic test_overrun;
    logic [2*DW-1:0] dropped;
    dout_ready = 1'b0;
    send_frame(32'h1111_0000, 32'h2222_0000, 16, 1'b1);
    send_frame(32'h4567_0000, 32'h89AB_0000, 16, 1'b1);
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b, required 0", overrun); end
    flush(0);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, required 1", overrun); end
    n_checks++;
    if ({dout_left, dout_right} !== exp_q[1]) begin
      n_fail++;
      $display("FAIL overrun_second_pair: got %h/%h, required %h/%h",
               dout_left, dout_right, exp_q[1][2*DW-1:DW], exp_q[1][DW-1:0]);
    end
    dropped = exp_q.pop_front();
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_valid_clear: got %b, required 0", dout_valid); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL overrun_drain: %0d pending, required 0", exp_q.size()); end
    dout_ready = 1'b1;
  endtask

  task automatic test_reset_midframe;
    dout_ready = 1'b0;
    send_frame(32'h1357_0000, 32'h2468_0000, 16, 1'b0);
    send_slot(1'b0, 32'h3333_0000, 16);
    send_slot(1'b1, 32'h4444_0000, 5);
    n_checks++;
    if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_valid: got %b, required 1", dout_valid); end
    resetn = 1'b0;
    tick(1);
    n_checks++;
    if (dout_left !== 16'h8000 || dout_right !== 16'h8000) begin
      n_fail++;
      $display("FAIL midreset_data: got %h/%h, required 8000/8000", dout_left, dout_right);
    end
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b, required 0", dout_valid); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_overrun: got %b, required 0", overrun); end
    resetn = 1'b1;
    dout_ready = 1'b1;
    send_slot(1'b1, 32'h4444_0000, 6);
    send_slot(1'b0, 32'hCAFE_0000, 16);
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_first_boundary: valid %b, required 0", dout_valid); end
    send_slot(1'b1, 32'hBEEF_0000, 16);
    exp_q.push_back({exp_word(32'hCAFE_0000, 16), exp_word(32'hBEEF_0000, 16)});
    flush(0);
    tick(2);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL midreset_drain: %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_long_slots();
    test_short_slots();
    test_back_to_back();
    test_simultaneous();
    test_overrun();
    test_reset_midframe();
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) tick(1);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL final_drain: %0d pending, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
